hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..15, meaning cycles a load occupies MEM.
REQ-003 SHALL have parameter DBG_EN, default 1, meaning debug halt/step logic present (0 = debug inputs ignored, FSM held in RUN).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 debug_en  in  1  request pipeline halt.
REQ-007 debug_step  in  1  step request, rising-edge sensitive.
REQ-008 id_rs, id_rt  in  ADDR_W each  ID-stage source registers.
REQ-009 rs_used, rt_used  in  1 each  ID instruction reads rs / rt.
REQ-010 id_is_store  in  1  ID instruction is a store.
REQ-011 exe_waddr, mem_waddr  in  ADDR_W each  destination register in EXE / MEM.
REQ-012 exe_wen, mem_wen  in  1 each  EXE / MEM instruction writes a register.
REQ-013 exe_ren, mem_ren  in  1 each  EXE / MEM instruction is a load.
REQ-014 branch_taken  in  1  ID branch/jump resolved taken.
REQ-015 stage_en  out  5  enables, bit0=IF .. bit4=WB.
REQ-016 stage_rst  out  5  stage flush/reset, same bit order.
REQ-017 fwd_a, fwd_b  out  2 each  EXE operand source: 0 reg, 1 EXE ALU, 2 MEM ALU, 3 MEM load data.
REQ-018 fwd_m  out  1  store data forwarded from MEM load result.
REQ-019 mem_wait  out  1  pipeline frozen for multi-cycle load.
REQ-020 dbg_halted  out  1  debug FSM in HALT.

Function
REQ-021 Forwarding, per operand (rs->fwd_a, rt->fwd_b), only when operand used and address != 0: EXE match with exe_wen and !exe_ren -> 1; else MEM match with mem_wen -> 3 if mem_ren, else 2; else 0.
REQ-022 EXE match on a used operand with exe_wen and exe_ren SHALL raise load-use stall, except rt of a store: then fwd_m=1, fwd_b=0, no stall.
REQ-023 EXE match SHALL take precedence over MEM match for the same operand.
REQ-024 Load-use stall: stage_en[1:0]=0, stage_rst[2]=1, others enabled.
REQ-025 Branch flush (branch_taken, no higher-priority condition): stage_rst[1]=1 for one cycle, all enabled.
REQ-026 Load wait: 4-bit counter; when mem_ren=1, counter=0, served flag clear and LOAD_LAT>1, load counter with LOAD_LAT-1 and set mem_wait.
REQ-027 While counter>0: decrement each cycle, mem_wait=1, stage_en=0, stage_rst=0; when counter reaches 0 set served flag, mem_wait=0 next cycle.
REQ-028 Served flag SHALL clear on any cycle with stage_en[3]=1 and mem_wait=0 (load leaves MEM); LOAD_LAT=1 SHALL never assert mem_wait.
REQ-029 Debug FSM states RUN, HALT, STEP: RUN->HALT when debug_en; HALT->STEP on debug_step rising edge (previous-cycle register); STEP->HALT unconditionally after one cycle; HALT or STEP -> RUN when debug_en=0.
REQ-030 In HALT all stage_en=0; in STEP pipeline behaves as RUN for exactly one cycle; dbg_halted=1 only in HALT.
REQ-031 Load-wait counter SHALL not decrement in HALT; STEP cycle counts as one wait cycle.
REQ-032 Priority: rst > debug HALT > load wait > load-use stall > branch flush > normal (all enabled, no reset).
REQ-033 Simultaneous load-use stall and branch_taken: stall only; branch re-evaluated next cycle.
REQ-034 Forwarding outputs SHALL be purely combinational on current inputs, independent of stall/halt state.

Reset
REQ-035 While rst=1: stage_rst=5'b11111, stage_en=5'b11111, fwd_a=fwd_b=0, fwd_m=0, mem_wait=0, dbg_halted=0.
REQ-036 On clock edge with rst=1: FSM -> RUN, counter -> 0, served -> 0, step-edge register -> 0; reset mid-wait or mid-halt SHALL abort it.

Verification
REQ-037 exe_waddr=5, exe_wen=1, exe_ren=0, id_rs=5, rs_used=1 -> fwd_a=1, stage_en=5'b11111.
REQ-038 exe_ren=1, exe_waddr=id_rt=7, rt_used=1, id_is_store=0 -> stage_en=5'b11100, stage_rst[2]=1; same with id_is_store=1 -> fwd_m=1, no stall.
REQ-039 LOAD_LAT=3, mem_ren=1 for 4 cycles -> mem_wait=1, stage_en=0 exactly 2 cycles, then pipeline advances once, no re-trigger.
REQ-040 debug_en=1 -> dbg_halted=1 next cycle, stage_en=0; debug_step 0->1 -> exactly one cycle stage_en=5'b11111, then halted.
REQ-041 branch_taken=1 with id_rs=0 -> stage_rst=5'b00010 one cycle; with concurrent load-use stall -> stage_rst=5'b00100 only.
REQ-042 rst asserted during mem_wait=1 -> all outputs at reset values next cycle, counter 0 after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Produces operand forwarding selects, per-stage enables and flushes,
// a multi-cycle load wait and a debug halt/single-step state machine.
//
// Output priority, highest first:
//   reset > debug halt > load wait > load-use stall > branch flush > normal
//
// Forwarding selects depend only on the current inputs. They are not
// affected by stall or halt state and are forced to zero only while rst is high.
//
// Load wait: a load reaching MEM while nothing is pending arms a down-counter
// with LOAD_LAT-1. mem_wait is the registered "counter non-zero" view, so the
// arming cycle itself still advances and the pipe then freezes for LOAD_LAT-1
// cycles. A served flag blocks re-arming on the same load until that load
// leaves MEM.
module hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int DBG_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              id_is_store,
    input  logic [ADDR_W-1:0] exe_waddr,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic              exe_wen,
    input  logic              mem_wen,
    input  logic              exe_ren,
    input  logic              mem_ren,
    input  logic              branch_taken,
    output logic [4:0]        stage_en,
    output logic [4:0]        stage_rst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_m,
    output logic              mem_wait,
    output logic              dbg_halted
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } dbg_state_t;

    localparam logic [1:0] FWD_REG  = 2'd0;
    localparam logic [1:0] FWD_EXE  = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_LOAD = 2'd3;

    localparam logic [3:0] WAIT_INIT   = 4'(LOAD_LAT - 1);
    localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
    localparam bit         DBG_ON      = (DBG_EN != 0);

    dbg_state_t state;
    logic       halted_q;
    logic       step_q;
    logic [3:0] wait_cnt;
    logic       served;

    // Per-operand match terms. Register 0 never forwards or stalls.
    logic rs_live, rt_live;
    logic rs_exe, rt_exe;
    logic rs_mem, rt_mem;
    logic load_use;
    logic step_rise;
    logic wait_active;
    logic load_arm;

    assign rs_live = rs_used && (id_rs != '0);
    assign rt_live = rt_used && (id_rt != '0);
    assign rs_exe  = rs_live && exe_wen && (id_rs == exe_waddr);
    assign rt_exe  = rt_live && exe_wen && (id_rt == exe_waddr);
    assign rs_mem  = rs_live && mem_wen && (id_rs == mem_waddr);
    assign rt_mem  = rt_live && mem_wen && (id_rt == mem_waddr);

    // A load in EXE feeding ID must stall, except store data on rt, which
    // is picked up later from the MEM load result instead.
    assign load_use = exe_ren && (rs_exe || (rt_exe && !id_is_store));

    assign step_rise   = debug_step && !step_q;
    assign wait_active = (wait_cnt != 4'd0);
    assign load_arm    = MULTI_CYCLE && mem_ren && !wait_active && !served && !halted_q;

    // Operand A select: EXE result beats MEM result; an EXE load gives no forward.
    always_comb begin
        fwd_a = FWD_REG;
        if (!rst) begin
            if (rs_exe) begin
                fwd_a = exe_ren ? FWD_REG : FWD_EXE;
            end else if (rs_mem) begin
                fwd_a = mem_ren ? FWD_LOAD : FWD_MEM;
            end
        end
    end

    // Operand B select and store-data forward from a load in EXE.
    always_comb begin
        fwd_b = FWD_REG;
        fwd_m = 1'b0;
        if (!rst) begin
            if (rt_exe) begin
                fwd_b = exe_ren ? FWD_REG : FWD_EXE;
                fwd_m = exe_ren && id_is_store;
            end else if (rt_mem) begin
                fwd_b = mem_ren ? FWD_LOAD : FWD_MEM;
            end
        end
    end

    // Stage enable / flush resolution in priority order.
    always_comb begin
        stage_en  = 5'b11111;
        stage_rst = 5'b00000;
        if (rst) begin
            stage_rst = 5'b11111;
        end else if (halted_q) begin
            stage_en = 5'b00000;
        end else if (wait_active) begin
            stage_en = 5'b00000;
        end else if (load_use) begin
            stage_en  = 5'b11100;
            stage_rst = 5'b00100;
        end else if (branch_taken) begin
            stage_rst = 5'b00010;
        end
    end

    assign mem_wait   = !rst && wait_active;
    assign dbg_halted = !rst && halted_q;

    // Previous-cycle copy of debug_step for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= debug_step;
        end
    end

    // Debug FSM; halted_q is the registered HALT indicator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            halted_q <= 1'b0;
        end else if (!DBG_ON) begin
            state    <= RUN;
            halted_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (debug_en) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: begin
                    if (!debug_en) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end else if (step_rise) begin
                        state    <= STEP;
                        halted_q <= 1'b0;
                    end
                end
                STEP: begin
                    if (!debug_en) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end else begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Load-wait counter and served flag; frozen while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            served   <= 1'b0;
        end else begin
            if (!halted_q) begin
                if (wait_active) begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        served <= 1'b1;
                    end
                end else if (load_arm) begin
                    wait_cnt <= WAIT_INIT;
                end
            end
            // The load leaves MEM on the first advancing cycle after its wait.
            if (served && stage_en[3] && !mem_wait) begin
                served <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (LOAD_LAT=3, debug logic present).
// Table-driven hazard vectors, hand-written multi-cycle sequences and a
// randomized run checked against a behavioural model of the controller.
module tb_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 3;

  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic clk = 1'b0;
  logic rst, debug_en, debug_step;
  logic [AW-1:0] id_rs, id_rt, exe_waddr, mem_waddr;
  logic rs_used, rt_used, id_is_store;
  logic exe_wen, mem_wen, exe_ren, mem_ren, branch_taken;
  logic [4:0] stage_en, stage_rst;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_m, mem_wait, dbg_halted;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int m_mode = M_RUN;
  int m_wait = 0;
  bit m_served = 1'b0;
  bit m_prev_step = 1'b0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic rs_used;
    logic rt_used;
    logic store;
    logic [4:0] ew;
    logic ewen;
    logic eren;
    logic [4:0] mw;
    logic mwen;
    logic mren;
    logic br;
    logic [16:0] exp;
    string name;
  } vec_t;

  vec_t vecs[$];

  hazard_ctrl #(.ADDR_W(AW), .LOAD_LAT(LAT), .DBG_EN(1)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .id_rs(id_rs), .id_rt(id_rt), .rs_used(rs_used), .rt_used(rt_used),
    .id_is_store(id_is_store), .exe_waddr(exe_waddr), .mem_waddr(mem_waddr),
    .exe_wen(exe_wen), .mem_wen(mem_wen), .exe_ren(exe_ren), .mem_ren(mem_ren),
    .branch_taken(branch_taken), .stage_en(stage_en), .stage_rst(stage_rst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m), .mem_wait(mem_wait),
    .dbg_halted(dbg_halted)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // packed view: {stage_en, stage_rst, fwd_a, fwd_b, fwd_m, mem_wait, dbg_halted}
  function automatic logic [16:0] pk(input logic [4:0] en, input logic [4:0] srst,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic fm, input logic mw, input logic h);
    return {en, srst, fa, fb, fm, mw, h};
  endfunction

  function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                              input logic rsu, input logic rtu, input logic st,
                              input logic [4:0] ew, input logic ewen, input logic eren,
                              input logic [4:0] mw, input logic mwen, input logic mren,
                              input logic br, input logic [16:0] exp);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.rs_used = rsu; v.rt_used = rtu; v.store = st;
    v.ew = ew; v.ewen = ewen; v.eren = eren; v.mw = mw; v.mwen = mwen; v.mren = mren;
    v.br = br; v.exp = exp;
    return v;
  endfunction

  // forwarding source for one operand, straight from the rules
  function automatic logic [1:0] model_src(input logic [4:0] a, input logic used);
    if (!used || a == 0) return 2'd0;
    if (exe_wen && exe_waddr == a) return exe_ren ? 2'd0 : 2'd1;
    if (mem_wen && mem_waddr == a) return mem_ren ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [16:0] model_out();
    logic [1:0] fa, fb;
    logic rs_lu, rt_lu, stall, fm;
    logic [4:0] en, srst;
    if (rst) return pk(5'h1f, 5'h1f, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    fa = model_src(id_rs, rs_used);
    fb = model_src(id_rt, rt_used);
    rs_lu = rs_used && id_rs != 0 && exe_wen && exe_ren && id_rs == exe_waddr;
    rt_lu = rt_used && id_rt != 0 && exe_wen && exe_ren && id_rt == exe_waddr;
    fm = rt_lu && id_is_store;
    stall = rs_lu || (rt_lu && !id_is_store);
    if (m_mode == M_HALT) begin
      en = 5'h00; srst = 5'h00;
    end else if (m_wait > 0) begin
      en = 5'h00; srst = 5'h00;
    end else if (stall) begin
      en = 5'b11100; srst = 5'b00100;
    end else if (branch_taken) begin
      en = 5'h1f; srst = 5'b00010;
    end else begin
      en = 5'h1f; srst = 5'h00;
    end
    return pk(en, srst, fa, fb, fm, (m_wait > 0), (m_mode == M_HALT));
  endfunction

  // advance the model by one clock using the inputs of this cycle
  task automatic model_advance();
    logic [16:0] o;
    bit old_served;
    bit waiting;
    o = model_out();
    if (rst) begin
      m_mode = M_RUN; m_wait = 0; m_served = 1'b0; m_prev_step = 1'b0;
      return;
    end
    old_served = m_served;
    waiting = (m_wait > 0);
    if (m_mode != M_HALT) begin
      if (m_wait > 0) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) m_served = 1'b1;
      end else if (mem_ren && !m_served && LAT > 1) begin
        m_wait = LAT - 1;
      end
    end
    if (o[15] && !waiting && old_served) m_served = 1'b0;
    case (m_mode)
      M_RUN:  if (debug_en) m_mode = M_HALT;
      M_HALT: if (!debug_en) m_mode = M_RUN;
              else if (debug_step && !m_prev_step) m_mode = M_STEP;
      default: m_mode = debug_en ? M_HALT : M_RUN;
    endcase
    m_prev_step = debug_step;
  endtask

  // driver: one clock; compare at negedge against exp_in or the model
  task automatic run_cycle(input string name, input bit use_exp, input logic [16:0] exp_in);
    logic [16:0] act, exp;
    @(negedge clk);
    act = {stage_en, stage_rst, fwd_a, fwd_b, fwd_m, mem_wait, dbg_halted};
    exp = use_exp ? exp_in : model_out();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = 0; id_rt = 0; rs_used = 0; rt_used = 0; id_is_store = 0;
    exe_waddr = 0; mem_waddr = 0; exe_wen = 0; mem_wen = 0;
    exe_ren = 0; mem_ren = 0; branch_taken = 0;
  endtask

  task automatic drain();
    set_idle();
    for (int k = 0; k < 8; k++) begin
      if (m_wait > 0 || m_served) run_cycle("drain", 1'b0, '0);
    end
  endtask

  localparam logic [16:0] RST_O = {5'h1f, 5'h1f, 7'd0};
  localparam logic [16:0] RUN_O = {5'h1f, 5'h00, 7'd0};
  localparam logic [16:0] HLT_O = {5'h00, 5'h00, 7'd1};
  localparam logic [16:0] WT_O  = {5'h00, 5'h00, 7'd2};

  initial begin
    rst = 1; debug_en = 0; debug_step = 0;
    set_idle();
    // reset with a live EXE match: forwarding must still read zero
    exe_waddr = 5; exe_wen = 1; id_rs = 5; rs_used = 1;
    run_cycle("reset_0", 1'b1, RST_O);
    run_cycle("reset_1", 1'b1, RST_O);
    rst = 0;
    run_cycle("after_reset", 1'b1, pk(5'h1f, 5'h0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0));
    set_idle();

    // hazard table:                    rs rt rsu rtu st ew ewen eren mw mwen mren br
    vecs.push_back(mk("exe_fwd_a",       5, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, pk(5'h1f, 5'h00, 2'd1, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("load_use_rt",     0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, pk(5'h1c, 5'h04, 2'd0, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("store_fwd_m",     0, 7, 0, 1, 1, 7, 1, 1, 0, 0, 0, 0, pk(5'h1f, 5'h00, 2'd0, 2'd0, 1, 0, 0)));
    vecs.push_back(mk("mem_alu_a",       3, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, pk(5'h1f, 5'h00, 2'd2, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("mem_load_b",      0, 4, 0, 1, 0, 0, 0, 0, 4, 1, 1, 0, pk(5'h1f, 5'h00, 2'd0, 2'd3, 0, 0, 0)));
    vecs.push_back(mk("exe_over_mem",    6, 6, 1, 1, 0, 6, 1, 0, 6, 1, 0, 0, pk(5'h1f, 5'h00, 2'd1, 2'd1, 0, 0, 0)));
    vecs.push_back(mk("reg_zero",        0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, pk(5'h1f, 5'h00, 2'd0, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("unused_rs",       9, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, pk(5'h1f, 5'h00, 2'd0, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("branch_flush",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(5'h1f, 5'h02, 2'd0, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("stall_over_br",   2, 0, 1, 0, 0, 2, 1, 1, 2, 1, 0, 1, pk(5'h1c, 5'h04, 2'd0, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("no_exe_wen",      8, 0, 1, 0, 0, 8, 0, 0, 8, 1, 0, 0, pk(5'h1f, 5'h00, 2'd2, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("store_rs_stall", 11, 0, 1, 0, 1, 11, 1, 1, 0, 0, 0, 0, pk(5'h1c, 5'h04, 2'd0, 2'd0, 0, 0, 0)));
    vecs.push_back(mk("both_mem_kinds", 12, 13, 1, 1, 0, 12, 1, 0, 13, 1, 0, 0, pk(5'h1f, 5'h00, 2'd1, 2'd2, 0, 0, 0)));

    for (int i = 0; i < vecs.size(); i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; rs_used = vecs[i].rs_used;
      rt_used = vecs[i].rt_used; id_is_store = vecs[i].store;
      exe_waddr = vecs[i].ew; exe_wen = vecs[i].ewen; exe_ren = vecs[i].eren;
      mem_waddr = vecs[i].mw; mem_wen = vecs[i].mwen; mem_ren = vecs[i].mren;
      branch_taken = vecs[i].br;
      run_cycle(vecs[i].name, 1'b1, vecs[i].exp);
      drain();
    end

    // branch re-evaluated after a combined stall
    id_rs = 2; rs_used = 1; exe_waddr = 2; exe_wen = 1; exe_ren = 1; branch_taken = 1;
    run_cycle("br_stall_c0", 1'b1, pk(5'h1c, 5'h04, 2'd0, 2'd0, 0, 0, 0));
    exe_wen = 0; exe_ren = 0;
    run_cycle("br_stall_c1", 1'b1, pk(5'h1f, 5'h02, 2'd0, 2'd0, 0, 0, 0));
    set_idle();

    // multi-cycle load held for four cycles: two wait cycles, no re-arm
    mem_ren = 1;
    run_cycle("load_arm", 1'b1, RUN_O);
    run_cycle("load_wait1", 1'b1, WT_O);
    run_cycle("load_wait2", 1'b1, WT_O);
    run_cycle("load_leave", 1'b1, RUN_O);
    mem_ren = 0;
    run_cycle("load_after", 1'b1, RUN_O);

    // debug halt and single step
    debug_en = 1;
    run_cycle("dbg_req", 1'b1, RUN_O);
    run_cycle("dbg_halt", 1'b1, HLT_O);
    debug_step = 1;
    run_cycle("dbg_step_edge", 1'b1, HLT_O);
    run_cycle("dbg_step_run", 1'b1, RUN_O);
    run_cycle("dbg_rehalt", 1'b1, HLT_O);
    run_cycle("dbg_step_held", 1'b1, HLT_O);
    debug_step = 0;
    debug_en = 0;
    run_cycle("dbg_release", 1'b1, HLT_O);
    run_cycle("dbg_running", 1'b1, RUN_O);

    // load wait frozen across a halt
    mem_ren = 1;
    run_cycle("hw_arm", 1'b1, RUN_O);
    mem_ren = 0;
    debug_en = 1;
    run_cycle("hw_wait1", 1'b1, WT_O);
    run_cycle("hw_halt_a", 1'b1, {5'h00, 5'h00, 7'd3});
    run_cycle("hw_halt_b", 1'b1, {5'h00, 5'h00, 7'd3});
    debug_en = 0;
    run_cycle("hw_halt_rel", 1'b1, {5'h00, 5'h00, 7'd3});
    run_cycle("hw_wait2", 1'b1, WT_O);
    run_cycle("hw_done", 1'b1, RUN_O);

    // reset in the middle of a load wait
    mem_ren = 1;
    run_cycle("rw_arm", 1'b1, RUN_O);
    mem_ren = 0;
    run_cycle("rw_wait", 1'b1, WT_O);
    rst = 1;
    run_cycle("rw_reset", 1'b1, RST_O);
    rst = 0;
    run_cycle("rw_clear", 1'b1, RUN_O);

    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) debug_en = ~debug_en;
      debug_step = ($urandom_range(0, 3) == 0);
      id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
      exe_waddr = AW'($urandom_range(0, 3)); mem_waddr = AW'($urandom_range(0, 3));
      rs_used = 1'($urandom); rt_used = 1'($urandom); id_is_store = 1'($urandom);
      exe_wen = 1'($urandom); mem_wen = 1'($urandom);
      exe_ren = 1'($urandom); mem_ren = ($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom);
      run_cycle("random", 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
